// File: rtl/demux1to2_stream.sv
// ============================================================================
// Module   : demux1to2_stream
// Brief    : Registered 1-to-2 valid/ready stream demux, route locked per packet.
// Revision : 1.0
// ============================================================================
`default_nettype none

module demux1to2_stream #(
  parameter int C_DW = 8,
  parameter int C_CW = 16
) (
  input  logic            I_clk,
  input  logic            I_rst,
  input  logic            I_sel,
  input  logic [C_DW-1:0] I_data,
  input  logic            I_valid,
  input  logic            I_last,
  output logic            O_ready,
  output logic [C_DW-1:0] O_data1,
  output logic            O_valid1,
  output logic            O_last1,
  input  logic            I_ready1,
  output logic [C_DW-1:0] O_data2,
  output logic            O_valid2,
  output logic            O_last2,
  input  logic            I_ready2,
  output logic [C_CW-1:0] O_pkt_cnt1,
  output logic [C_CW-1:0] O_pkt_cnt2
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_LOCK1 = 2'd1;
  localparam logic [1:0] c_LOCK2 = 2'd2;

  logic [1:0]      r_state;
  logic [C_DW-1:0] r_data1, r_data2;
  logic            r_valid1, r_valid2;
  logic            r_last1, r_last2;
  logic [C_CW-1:0] r_cnt1, r_cnt2;

  logic w_path1;
  logic w_ready;
  logic w_acc;
  logic w_load1, w_load2;

  // I_sel only matters while idle; once a packet has started the route is pinned.
  always_comb begin
    w_path1 = 1'b0;
    if (r_state == c_IDLE) w_path1 = I_sel;
    else                   w_path1 = (r_state == c_LOCK1);
  end

  assign w_ready = w_path1 ? (!r_valid1 | I_ready1) : (!r_valid2 | I_ready2);
  assign w_acc   = I_valid & w_ready;
  assign w_load1 = w_acc & w_path1;
  assign w_load2 = w_acc & !w_path1;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state <= c_IDLE;
    end else if (w_acc) begin
      if (r_state == c_IDLE) begin
        if (!I_last) r_state <= w_path1 ? c_LOCK1 : c_LOCK2;
      end else if (I_last) begin
        r_state <= c_IDLE;
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_data1  <= '0;
      r_last1  <= 1'b0;
      r_valid1 <= 1'b0;
      r_cnt1   <= '0;
    end else begin
      if (w_load1) begin
        r_data1  <= I_data;
        r_last1  <= I_last;
        r_valid1 <= 1'b1;
      end else if (r_valid1 && I_ready1) begin
        r_valid1 <= 1'b0;
      end
      if (r_valid1 && I_ready1 && r_last1) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_data2  <= '0;
      r_last2  <= 1'b0;
      r_valid2 <= 1'b0;
      r_cnt2   <= '0;
    end else begin
      if (w_load2) begin
        r_data2  <= I_data;
        r_last2  <= I_last;
        r_valid2 <= 1'b1;
      end else if (r_valid2 && I_ready2) begin
        r_valid2 <= 1'b0;
      end
      if (r_valid2 && I_ready2 && r_last2) r_cnt2 <= r_cnt2 + 1'b1;
    end
  end

  assign O_ready    = w_ready;
  assign O_data1    = r_data1;
  assign O_valid1   = r_valid1;
  assign O_last1    = r_last1;
  assign O_data2    = r_data2;
  assign O_valid2   = r_valid2;
  assign O_last2    = r_last2;
  assign O_pkt_cnt1 = r_cnt1;
  assign O_pkt_cnt2 = r_cnt2;

endmodule

`default_nettype wire

// File: tb/tb_demux1to2_stream.sv
// ============================================================================
// Module   : tb_demux1to2_stream
// Brief    : Directed self-checking bench for demux1to2_stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_demux1to2_stream;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic        I_sel;
  logic [7:0]  I_data;
  logic        I_valid;
  logic        I_last;
  logic        O_ready;
  logic [7:0]  O_data1;
  logic        O_valid1;
  logic        O_last1;
  logic        I_ready1;
  logic [7:0]  O_data2;
  logic        O_valid2;
  logic        O_last2;
  logic        I_ready2;
  logic [15:0] O_pkt_cnt1;
  logic [15:0] O_pkt_cnt2;

  int n_checks = 0;
  int n_errors = 0;

  demux1to2_stream #(.C_DW(8), .C_CW(16)) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_sel(I_sel), .I_data(I_data),
    .I_valid(I_valid), .I_last(I_last), .O_ready(O_ready),
    .O_data1(O_data1), .O_valid1(O_valid1), .O_last1(O_last1), .I_ready1(I_ready1),
    .O_data2(O_data2), .O_valid2(O_valid2), .O_last2(O_last2), .I_ready2(I_ready2),
    .O_pkt_cnt1(O_pkt_cnt1), .O_pkt_cnt2(O_pkt_cnt2)
  );

  always #5 I_clk = ~I_clk;

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    I_rst = 1'b1; I_sel = 1'b0; I_data = 8'h00; I_valid = 1'b0; I_last = 1'b0;
    I_ready1 = 1'b1; I_ready2 = 1'b1;
    tick();
    tick();
    I_rst = 1'b0;
    chk("rst_valid1", {31'd0, O_valid1}, 32'd0);
    chk("rst_valid2", {31'd0, O_valid2}, 32'd0);
    chk("rst_data1", {24'd0, O_data1}, 32'd0);
    chk("rst_cnt1", {16'd0, O_pkt_cnt1}, 32'd0);
    chk("rst_cnt2", {16'd0, O_pkt_cnt2}, 32'd0);

    // 1: three-beat packet to output 1
    I_sel = 1'b1; I_valid = 1'b1; I_data = 8'hAA; I_last = 1'b0;
    #1 chk("t1_ready", {31'd0, O_ready}, 32'd1);
    tick();
    chk("t1_d0", {24'd0, O_data1}, 32'hAA);
    chk("t1_v0", {31'd0, O_valid1}, 32'd1);
    chk("t1_v2a", {31'd0, O_valid2}, 32'd0);
    I_data = 8'hBB;
    tick();
    chk("t1_d1", {24'd0, O_data1}, 32'hBB);
    chk("t1_l1", {31'd0, O_last1}, 32'd0);
    I_data = 8'hCC; I_last = 1'b1;
    tick();
    chk("t1_d2", {24'd0, O_data1}, 32'hCC);
    chk("t1_l2", {31'd0, O_last1}, 32'd1);
    chk("t1_v2b", {31'd0, O_valid2}, 32'd0);
    I_valid = 1'b0; I_last = 1'b0;
    tick();
    chk("t1_cnt1", {16'd0, O_pkt_cnt1}, 32'd1);
    chk("t1_vend", {31'd0, O_valid1}, 32'd0);

    // 2: four-beat packet on output 2 while I_sel toggles
    I_valid = 1'b1; I_sel = 1'b0; I_data = 8'h10;
    tick();
    chk("t2_d0", {24'd0, O_data2}, 32'h10);
    I_sel = 1'b1; I_data = 8'h11;
    tick();
    chk("t2_d1", {24'd0, O_data2}, 32'h11);
    chk("t2_v1a", {31'd0, O_valid1}, 32'd0);
    I_sel = 1'b0; I_data = 8'h12;
    tick();
    chk("t2_d2", {24'd0, O_data2}, 32'h12);
    I_sel = 1'b1; I_data = 8'h13; I_last = 1'b1;
    tick();
    chk("t2_d3", {24'd0, O_data2}, 32'h13);
    chk("t2_l3", {31'd0, O_last2}, 32'd1);
    chk("t2_v1b", {31'd0, O_valid1}, 32'd0);
    I_valid = 1'b0; I_last = 1'b0;
    tick();
    chk("t2_cnt2", {16'd0, O_pkt_cnt2}, 32'd1);
    chk("t2_cnt1", {16'd0, O_pkt_cnt1}, 32'd1);

    // 3: output 1 stalled while input streams (also proves FSM went back to IDLE)
    I_ready1 = 1'b0; I_sel = 1'b1; I_valid = 1'b1; I_data = 8'h20;
    #1 chk("t3_rdy0", {31'd0, O_ready}, 32'd1);
    tick();
    chk("t3_d0", {24'd0, O_data1}, 32'h20);
    chk("t3_v2", {31'd0, O_valid2}, 32'd0);
    I_data = 8'h21;
    #1 chk("t3_stall", {31'd0, O_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_hold", {24'd0, O_data1}, 32'h20);
      chk("t3_hrdy", {31'd0, O_ready}, 32'd0);
    end
    I_ready1 = 1'b1;
    #1 chk("t3_rdy1", {31'd0, O_ready}, 32'd1);
    tick();
    chk("t3_d1", {24'd0, O_data1}, 32'h21);
    I_data = 8'h22; I_last = 1'b1;
    tick();
    chk("t3_d2", {24'd0, O_data1}, 32'h22);
    I_valid = 1'b0; I_last = 1'b0; I_ready1 = 1'b0;
    tick();
    chk("t3_full", {31'd0, O_valid1}, 32'd1);

    // 4: output 1 stalled and full, output 2 streams
    I_sel = 1'b0; I_ready2 = 1'b1; I_valid = 1'b1; I_data = 8'h30;
    #1 chk("t4_rdy", {31'd0, O_ready}, 32'd1);
    tick();
    chk("t4_d0", {24'd0, O_data2}, 32'h30);
    chk("t4_h1a", {24'd0, O_data1}, 32'h22);
    chk("t4_both", {30'd0, O_valid1, O_valid2}, 32'd3);
    I_data = 8'h31; I_last = 1'b1;
    tick();
    chk("t4_d1", {24'd0, O_data2}, 32'h31);
    chk("t4_h1b", {24'd0, O_data1}, 32'h22);
    I_valid = 1'b0; I_last = 1'b0;
    tick();
    chk("t4_cnt2", {16'd0, O_pkt_cnt2}, 32'd2);
    chk("t4_cnt1s", {16'd0, O_pkt_cnt1}, 32'd1);
    I_ready1 = 1'b1;
    tick();
    chk("t4_cnt1", {16'd0, O_pkt_cnt1}, 32'd2);
    chk("t4_v1", {31'd0, O_valid1}, 32'd0);

    // 5: reset in the middle of a packet on path 1
    I_sel = 1'b1; I_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      I_data = 8'h40 + 8'(i);
      tick();
    end
    chk("t5_d2", {24'd0, O_data1}, 32'h42);
    I_data = 8'h43; I_rst = 1'b1;
    tick();
    I_rst = 1'b0;
    chk("t5_v1", {31'd0, O_valid1}, 32'd0);
    chk("t5_cnt", {O_pkt_cnt1, O_pkt_cnt2}, 32'd0);
    I_sel = 1'b0; I_data = 8'h50; I_last = 1'b1;
    tick();
    chk("t5_fresh", {30'd0, O_valid1, O_valid2}, 32'd1);
    chk("t5_d", {24'd0, O_data2}, 32'h50);
    I_valid = 1'b0;
    tick();
    chk("t5_cnt2", {16'd0, O_pkt_cnt2}, 32'd1);

    // 6: counter wrap on output 2
    I_valid = 1'b1; I_last = 1'b1; I_sel = 1'b0;
    repeat (65534) tick();
    I_valid = 1'b0;
    tick();
    chk("t6_max", {16'd0, O_pkt_cnt2}, 32'hFFFF);
    I_valid = 1'b1;
    tick();
    I_valid = 1'b0;
    tick();
    chk("t6_wrap", {16'd0, O_pkt_cnt2}, 32'h0000);
    chk("t6_cnt1", {16'd0, O_pkt_cnt1}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
